// File: rtl/axi_sram_slave_pkg.sv
// Shared constants and helpers for the AXI SRAM slave: response/burst codes,
// FSM state encodings, the captured-request struct and the burst address step.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  // WRAP is deliberately stepped like INCR; the add wraps modulo 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    next_addr = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int aw);
    in_range = (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-wide SRAM array: byte-enable synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational; no backpressure.
// Reads in the same cycle as a write to the same word see the old contents.
module axi_sram_mem #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-3:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-3:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM slave with independent write and read FSMs, one outstanding burst each.
// Latency: rvalid 2 cycles after AR / each non-last R handshake (+WAIT_CYCLES with AXI_SRAM_WAIT_EN).
// Backpressure: bvalid/bid and rdata/rresp/rlast hold until bready/rready.
module axi_sram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  import axi_sram_slave_pkg::*;

  logic [1:0]  w_state;
  req_t        aw_q;
  logic [3:0]  w_cnt;
  logic        w_err;
  logic [1:0]  bresp_q;
  logic        w_in_range;
  logic        w_last;
  logic        w_beat_err;

  logic [1:0]  r_state;
  req_t        ar_q;
  logic [3:0]  r_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic        r_in_range;
  logic        wait_done;
  logic [31:0] mem_rdata;
  logic        unused_ok;

  assign w_in_range = in_range(aw_q.addr, ADDR_WIDTH);
  assign w_last     = (w_cnt == aw_q.len);
  assign w_beat_err = !w_in_range || (wlast != w_last);
  assign r_in_range = in_range(ar_q.addr, ADDR_WIDTH);

  axi_sram_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (aclk),
    .we    (w_state == W_DATA && wvalid && w_in_range),
    .waddr (aw_q.addr[ADDR_WIDTH-1:2]),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (ar_q.addr[ADDR_WIDTH-1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      aw_q    <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          aw_q    <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          // Beat count alone ends the burst; wlast only feeds the error status.
          if (w_last) begin
            bresp_q <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end else begin
            w_err     <= w_err || w_beat_err;
            aw_q.addr <= next_addr(aw_q.addr, aw_q.size, aw_q.burst);
            w_cnt     <= w_cnt + 4'd1;
          end
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = aw_q.id;
  assign bresp   = bresp_q;

`ifdef AXI_SRAM_WAIT_EN
  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WCW-1:0] wait_cnt;

  // Reloaded whenever the read FSM is about to enter R_WAIT.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wait_cnt <= '0;
    end else if ((r_state == R_IDLE && arvalid) ||
                 (r_state == R_DATA && rready && !rlast_q)) begin
      wait_cnt <= WCW'(WAIT_CYCLES);
    end else if (r_state == R_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign wait_done = (wait_cnt == '0);
  assign unused_ok = ^{awlock, awcache, awprot, wid, arlock, arcache, arprot};
`else
  assign wait_done = 1'b1;
  assign unused_ok = ^{awlock, awcache, awprot, wid, arlock, arcache, arprot,
                       (WAIT_CYCLES != 0)};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      ar_q    <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          ar_q    <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
          r_cnt   <= '0;
          r_state <= R_WAIT;
        end
        R_WAIT: if (wait_done) begin
          rdata_q <= r_in_range ? mem_rdata : 32'd0;
          rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
          rlast_q <= (r_cnt == ar_q.len);
          r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast_q) begin
            r_state <= R_IDLE;
          end else begin
            ar_q.addr <= next_addr(ar_q.addr, ar_q.size, ar_q.burst);
            r_cnt     <= r_cnt + 4'd1;
            r_state   <= R_WAIT;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid && rlast_q;
  assign rid     = ar_q.id;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
